mux16_rr_sched: RTL and testbench
=================================

MUX16_RR_SCHED -- requirements
Module: mux16_rr_sched

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: the maximum number of transfers one owner may complete per grant. The legal range is 1..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the clk rising edge.
REQ-004 SHALL have port req, input, 16 bits: bit i is the request from requester i.
REQ-005 SHALL have port ready, input, 1 bit: the downstream consumer of the shared 16:1 mux output accepts a beat.
REQ-006 SHALL have port sel, output, 4 bits: registered select driven to the shared mux_16x1 instance.
REQ-007 SHALL have port gnt, output, 16 bits: registered one-hot grant, all-zero when there is no owner.
REQ-008 SHALL have port valid, output, 1 bit: the mux output is valid for the current owner.
REQ-009 SHALL have port last, output, 1 bit: the current beat is the final beat permitted in this grant.
REQ-010 SHALL have port abort, output, 1 bit: one-cycle pulse when the owner drops req with a beat pending.

Function
REQ-011 SHALL implement a 2-state FSM with states IDLE (no owner) and OWN (owner latched in sel/gnt).
REQ-012 SHALL, in IDLE with req != 0, select the first requester i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod 16; load sel=i and gnt=1<<i, clear beat_cnt, and enter OWN on the next edge.
REQ-013 SHALL, in IDLE with req == 0, remain in IDLE with gnt=0; sel holds its last value.
REQ-014 SHALL drive valid = (state==OWN) & req[sel], combinationally from registered state.
REQ-015 SHALL define a transfer as valid & ready on a rising edge; beat_cnt (4 bits) increments by 1 per transfer.
REQ-016 SHALL drive last = valid & (beat_cnt == MAX_BURST-1).
REQ-017 SHALL release ownership, entering IDLE on the next edge, when either condition holds: a transfer occurs with last=1, or req[sel]=0 while in OWN.
REQ-018 SHALL, on release, set rr_ptr = (sel+1) mod 16, wrapping 15 to 0; clear gnt; and clear beat_cnt.
REQ-019 SHALL pulse abort for exactly one cycle when release is caused by req[sel]=0 and the previous cycle had valid=1 & ready=0.
REQ-020 SHALL hold sel, gnt and beat_cnt stable while valid=1 & ready=0 (no preemption mid-beat).
REQ-021 SHALL ignore requests from non-owners in OWN; they are considered only at the next IDLE arbitration.
REQ-022 SHALL insert exactly one IDLE cycle between consecutive owners, so grant-to-grant latency is 1 clk after release.
REQ-023 SHALL, for MAX_BURST=1, release after every single transfer.
REQ-024 SHALL re-grant the same requester if it is the only one requesting after its release, following a one-cycle IDLE gap.

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, set state=IDLE, sel=0, gnt=0, rr_ptr=0, beat_cnt=0, and abort=0; valid and last are 0 as a consequence.
REQ-026 SHALL let reset override all activity, including mid-burst and during valid & !ready; no transfer is counted on the reset edge.
REQ-027 SHALL, on the first edge with rst_n=1, arbitrate normally from rr_ptr=0.

Verification
REQ-028 SHALL cover the basic burst: reset, then req=16'h0001 and ready=1.
  - Expected: gnt=0001 and sel=0 one cycle after reset release.
  - Expected: 4 transfers, with last on the 4th.
  - Expected: IDLE 1 cycle, then re-grant to 0.
REQ-029 SHALL cover round-robin and wrap-around: req=16'h8001 held, ready=1, MAX_BURST=4.
  - Expected grant order 0, 15, 0, 15, with sel toggling 0 to F to 0.
  - Expected: rr_ptr wraps 0 after owner 15 is released.
REQ-030 SHALL cover backpressure: owner 3 granted, ready=0 for 5 cycles.
  - Expected: valid=1 stable, sel=3 stable, beat_cnt=0.
  - Expected: req[7]=1 during this window causes no grant change.
REQ-031 SHALL cover abort: owner 5 with valid=1 and ready=0, then req[5] falls.
  - Expected: abort=1 for one cycle and state to IDLE.
  - Expected: next grant goes to the lowest requester at or after 6.
REQ-032 SHALL cover reset mid-burst: owner 9 after 2 beats, then rst_n=0 for 1 cycle.
  - Expected: gnt=0, sel=0, valid=0.
  - Expected with req=16'h0200 afterward: grant to 9 with a fresh 4-beat count.
REQ-033 SHALL cover the MAX_BURST=1 case: req=16'hFFFF, ready=1.
  - Expected grants 0, 1, 2, ... 15, 0, each for one transfer separated by one IDLE cycle.

Source files
------------

// File: rtl/mux16_rr_sched.sv
// ---------------------------------------------------------------------------
// mux16_rr_sched
//
// Round-robin owner scheduler for a shared 16:1 mux. In IDLE it picks one
// requester, scanning upward from the round-robin pointer. It then holds that
// owner in sel/gnt for up to MAX_BURST accepted beats before handing the mux on.
// There is always one IDLE cycle between two owners.
//
// Ports
//   clk    in   1   single clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   req    in  16   per-requester request lines
//   ready  in   1   downstream accepts the current beat
//   sel    out  4   registered select to the shared mux
//   gnt    out 16   registered one-hot grant, zero when there is no owner
//   valid  out  1   mux output is valid for the current owner
//   last   out  1   current beat is the final one allowed in this grant
//   abort  out  1   one-cycle pulse: owner dropped req with a beat stalled
// ---------------------------------------------------------------------------
module mux16_rr_sched #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        ready,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        valid,
    output logic        last,
    output logic        abort
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t      state_r;
    logic [3:0]  sel_r;
    logic [15:0] gnt_r;
    logic [3:0]  rr_ptr_r;
    logic [3:0]  beat_cnt_r;
    logic        abort_r;
    logic        stall_r;     // previous cycle had valid & !ready

    logic        owner_req_s;
    logic        valid_s;
    logic        last_s;
    logic        xfer_s;
    logic        drop_s;
    logic        done_s;
    logic        any_req_s;
    logic [3:0]  pick_s;

    // First requester at or after ptr, wrapping mod 16. Offsets are walked
    // from high to low so the smallest offset overwrites the others.
    function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] ptr);
        logic [3:0] idx;
        logic [3:0] pick;
        pick = ptr;
        for (int off = 15; off >= 0; off--) begin
            idx  = ptr + 4'(off);
            pick = r[idx] ? idx : pick;
        end
        return pick;
    endfunction

    // Owner status decoded from registered state and the live request lines
    always_comb begin
        owner_req_s = req[sel_r];
        valid_s     = (state_r == OWN) && owner_req_s;
        last_s      = valid_s && (beat_cnt_r == LAST_BEAT);
        xfer_s      = valid_s && ready;
        drop_s      = (state_r == OWN) && !owner_req_s;
        done_s      = (xfer_s && last_s) || drop_s;
        any_req_s   = |req;
        pick_s      = rr_pick(req, rr_ptr_r);
    end

    // Ownership FSM with registered select, grant and abort
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sel_r      <= 4'd0;
            gnt_r      <= 16'd0;
            rr_ptr_r   <= 4'd0;
            beat_cnt_r <= 4'd0;
            abort_r    <= 1'b0;
            stall_r    <= 1'b0;
        end else begin
            abort_r <= 1'b0;
            stall_r <= valid_s && !ready;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r    <= OWN;
                        sel_r      <= pick_s;
                        gnt_r      <= 16'd1 << pick_s;
                        beat_cnt_r <= 4'd0;
                    end else begin
                        gnt_r      <= 16'd0;
                    end
                end
                OWN: begin
                    if (done_s) begin
                        // Release: hand priority to the next index after the owner.
                        // sel keeps pointing at the old owner until the next grant.
                        state_r    <= IDLE;
                        gnt_r      <= 16'd0;
                        beat_cnt_r <= 4'd0;
                        rr_ptr_r   <= sel_r + 4'd1;
                        abort_r    <= drop_s && stall_r;
                    end else if (xfer_s) begin
                        beat_cnt_r <= beat_cnt_r + 4'd1;
                    end else begin
                        // Stalled beat: everything holds.
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    gnt_r      <= 16'd0;
                    beat_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign sel   = sel_r;
    assign gnt   = gnt_r;
    assign abort = abort_r;
    assign valid = valid_s;
    assign last  = last_s;

endmodule

// File: tb/tb_mux16_rr_sched.sv
module tb_mux16_rr_sched;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        ready;

    logic [3:0]  sel4,   sel1;
    logic [15:0] gnt4,   gnt1;
    logic        valid4, valid1;
    logic        last4,  last1;
    logic        abort4, abort1;

    logic        use_mb1;
    logic [3:0]  o_sel;
    logic [15:0] o_gnt;
    logic        o_valid, o_last, o_abort;

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        valid;
        logic        last;
        logic        abort;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    mux16_rr_sched #(.MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
        .sel(sel4), .gnt(gnt4), .valid(valid4), .last(last4), .abort(abort4)
    );

    mux16_rr_sched #(.MAX_BURST(1)) dut_mb1 (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
        .sel(sel1), .gnt(gnt1), .valid(valid1), .last(last1), .abort(abort1)
    );

    assign o_sel   = use_mb1 ? sel1   : sel4;
    assign o_gnt   = use_mb1 ? gnt1   : gnt4;
    assign o_valid = use_mb1 ? valid1 : valid4;
    assign o_last  = use_mb1 ? last1  : last4;
    assign o_abort = use_mb1 ? abort1 : abort4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_head();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        assert (o_gnt === e.gnt) else begin
            n_fail++;
            $error("FAIL %s gnt observed=%h expected=%h", t, o_gnt, e.gnt);
        end
        n_tests++;
        assert (o_sel === e.sel) else begin
            n_fail++;
            $error("FAIL %s sel observed=%h expected=%h", t, o_sel, e.sel);
        end
        n_tests++;
        assert (o_valid === e.valid) else begin
            n_fail++;
            $error("FAIL %s valid observed=%b expected=%b", t, o_valid, e.valid);
        end
        n_tests++;
        assert (o_last === e.last) else begin
            n_fail++;
            $error("FAIL %s last observed=%b expected=%b", t, o_last, e.last);
        end
        n_tests++;
        assert (o_abort === e.abort) else begin
            n_fail++;
            $error("FAIL %s abort observed=%b expected=%b", t, o_abort, e.abort);
        end
    endtask

    // Drive one cycle of inputs, queue what the outputs must be during this
    // cycle, compare, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [15:0] r, input logic rd, input logic rn,
                       input logic [15:0] eg, input logic [3:0] es,
                       input logic ev, input logic el, input logic ea);
        exp_t e;
        req   = r;
        ready = rd;
        rst_n = rn;
        e.gnt   = eg;
        e.sel   = es;
        e.valid = ev;
        e.last  = el;
        e.abort = ea;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        check_head();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input logic [15:0] r, input logic rd, input logic rn);
        req   = r;
        ready = rd;
        rst_n = rn;
        @(posedge clk);
        #1;
    endtask

    // n accepted beats from one owner; last expected on beat mb
    task automatic burst(input string tag, input logic [15:0] r, input logic [3:0] owner,
                         input int n, input int mb);
        for (int k = 0; k < n; k++) begin
            cyc(tag, r, 1'b1, 1'b1, 16'd1 << owner, owner, 1'b1, (k == mb - 1), 1'b0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        use_mb1 = 1'b0;
        req     = 16'h0000;
        ready   = 1'b0;
        rst_n   = 1'b0;

        // Reset state on both instances
        idle_cyc(16'h0000, 1'b0, 1'b0);
        idle_cyc(16'h0000, 1'b0, 1'b0);
        cyc("reset", 16'h0000, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
        use_mb1 = 1'b1;
        cyc("reset_mb1", 16'h0000, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
        use_mb1 = 1'b0;

        // Basic burst and re-grant of a lone requester
        cyc("t1_idle", 16'h0001, 1'b1, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
        burst("t1_burst", 16'h0001, 4'h0, 4, 4);
        cyc("t1_gap", 16'h0001, 1'b1, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
        burst("t1_regrant", 16'h0001, 4'h0, 4, 4);
        cyc("t1_end", 16'h0000, 1'b1, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);

        // Round robin between 0 and 15 with pointer wrap
        cyc("t2_rst", 16'h0000, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("t2_idle", 16'h8001, 1'b1, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int rep = 0; rep < 2; rep++) begin
            burst("t2_own0", 16'h8001, 4'h0, 4, 4);
            cyc("t2_gap0", 16'h8001, 1'b1, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
            burst("t2_own15", 16'h8001, 4'hF, 4, 4);
            cyc("t2_gap15", (rep == 1) ? 16'h0000 : 16'h8001, 1'b1, 1'b1,
                16'h0000, 4'hF, 1'b0, 1'b0, 1'b0);
        end

        // Backpressure on owner 3 while requester 7 waits
        cyc("t3_idle", 16'h0008, 1'b1, 1'b1, 16'h0000, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc("t3_stall", 16'h0088, 1'b0, 1'b1, 16'h0008, 4'h3, 1'b1, 1'b0, 1'b0);
        end
        burst("t3_burst", 16'h0088, 4'h3, 4, 4);
        cyc("t3_gap", 16'h0080, 1'b1, 1'b1, 16'h0000, 4'h3, 1'b0, 1'b0, 1'b0);
        cyc("t3_own7_drop", 16'h0000, 1'b1, 1'b1, 16'h0080, 4'h7, 1'b0, 1'b0, 1'b0);
        cyc("t3_noabort", 16'h0000, 1'b1, 1'b1, 16'h0000, 4'h7, 1'b0, 1'b0, 1'b0);

        // Abort: owner 5 stalls then drops its request
        cyc("t4_idle", 16'h0020, 1'b0, 1'b1, 16'h0000, 4'h7, 1'b0, 1'b0, 1'b0);
        cyc("t4_stall", 16'h0020, 1'b0, 1'b1, 16'h0020, 4'h5, 1'b1, 1'b0, 1'b0);
        cyc("t4_drop", 16'h0410, 1'b0, 1'b1, 16'h0020, 4'h5, 1'b0, 1'b0, 1'b0);
        cyc("t4_abort", 16'h0410, 1'b1, 1'b1, 16'h0000, 4'h5, 1'b0, 1'b0, 1'b1);
        cyc("t4_next", 16'h0410, 1'b1, 1'b1, 16'h0400, 4'hA, 1'b1, 1'b0, 1'b0);
        cyc("t4_drop2", 16'h0010, 1'b1, 1'b1, 16'h0400, 4'hA, 1'b0, 1'b0, 1'b0);
        cyc("t4_noabort", 16'h0000, 1'b1, 1'b1, 16'h0000, 4'hA, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a burst from owner 9
        cyc("t5_idle", 16'h0200, 1'b1, 1'b1, 16'h0000, 4'hA, 1'b0, 1'b0, 1'b0);
        cyc("t5_beat", 16'h0200, 1'b1, 1'b1, 16'h0200, 4'h9, 1'b1, 1'b0, 1'b0);
        cyc("t5_beat", 16'h0200, 1'b1, 1'b1, 16'h0200, 4'h9, 1'b1, 1'b0, 1'b0);
        cyc("t5_rst_edge", 16'h0200, 1'b1, 1'b0, 16'h0200, 4'h9, 1'b1, 1'b0, 1'b0);
        cyc("t5_after_rst", 16'h0200, 1'b1, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
        burst("t5_fresh", 16'h0200, 4'h9, 4, 4);
        cyc("t5_end", 16'h0000, 1'b1, 1'b1, 16'h0000, 4'h9, 1'b0, 1'b0, 1'b0);

        // MAX_BURST=1: one transfer per grant, walking all 16 requesters
        use_mb1 = 1'b1;
        idle_cyc(16'h0000, 1'b0, 1'b0);
        cyc("t6_idle", 16'hFFFF, 1'b1, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            cyc("t6_own", 16'hFFFF, 1'b1, 1'b1, 16'd1 << (i % 16), 4'(i % 16),
                1'b1, 1'b1, 1'b0);
            cyc("t6_gap", (i == 16) ? 16'h0000 : 16'hFFFF, 1'b1, 1'b1,
                16'h0000, 4'(i % 16), 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
